wb_trace_checker: RTL and testbench
===================================

# wb_trace_checker

Consumes the per-instruction write-back debug trace produced by the SoC top (`debug_wb_have_inst`, `debug_wb_pc`, `debug_wb_ena`, `debug_wb_reg`, `debug_wb_value`). It compares each retired instruction against a golden trace held in an external asynchronous-read ROM. Results are reported as sticky pass/fail status with diagnostic capture. It sits beside `miniRV_SoC` in the test harness or on the FPGA, driven by the same clock.

## Interface
- `TRACE_DEPTH`, default 1024: number of golden entries; reaching this count means pass.
- `ADDR_W`, default 10: width of `gold_addr`; must satisfy 2^ADDR_W ≥ TRACE_DEPTH.
- `TIMEOUT`, default 65535: maximum idle cycles between retirements while running.
- `fpga_clk` in 1: the single clock. Reset is synchronous and active-high.
- `fpga_rst` in 1: synchronous, active-high reset.
- `debug_wb_have_inst` in 1: an instruction retires this cycle.
- `debug_wb_pc` in 32: PC of the retiring instruction.
- `debug_wb_ena` in 1: register-file write enable of the retiring instruction.
- `debug_wb_reg` in 5: destination register.
- `debug_wb_value` in 32: write data.
- `gold_addr` out ADDR_W: registered index of the next expected entry.
- `gold_entry` in 70: combinational ROM data at `gold_addr`, laid out as {pc[69:38], ena[37], reg[36:32], value[31:0]}.
- `chk_done` out 1: sticky; the check has finished (pass or fail).
- `chk_pass` out 1: sticky; all TRACE_DEPTH entries matched.
- `chk_fail` out 1: sticky; a mismatch or timeout occurred.
- `fail_code` out 3: 0 none, 1 pc, 2 ena, 3 reg, 4 value, 5 timeout.
- `fail_index` out ADDR_W: entry index at the failure.
- `fail_got` out 32: DUT field that mismatched (pc or value; reg/ena zero-extended; 0 on timeout).
- `fail_exp` out 32: golden field corresponding to `fail_got`.
- `retired_cnt` out 32: number of instructions compared.

## Operation
- States: IDLE, RUN, PASS, FAIL.
  - IDLE → RUN: on the first cycle with `debug_wb_have_inst`=1. That instruction is compared in the same cycle.
  - RUN → PASS: when a matching compare brings the index to TRACE_DEPTH.
  - RUN → FAIL: on any mismatch, or when the idle counter reaches TIMEOUT.
  - PASS and FAIL are terminal until `fpga_rst`. Further `have_inst` is ignored; `retired_cnt` and `gold_addr` freeze.
- Compare rules, applied only when `have_inst`=1 in IDLE or RUN:
  - pc: `debug_wb_pc` must equal gold pc.
  - Effective write: DUT_w = ena & (reg≠0); GOLD_w = gold ena & (gold reg≠0). DUT_w≠GOLD_w is an ena mismatch.
  - If both writes are effective, reg and then value must match. If neither is effective, reg and value are don't-care.
  - Priority when several fields are wrong: pc > ena > reg > value. Only the highest-priority failure is recorded.
- On a match: `gold_addr` increments (no wrap; PASS is entered at TRACE_DEPTH) and `retired_cnt` increments.
- On a mismatch: `fail_*` registers capture the index and fields; `retired_cnt` does not increment.
- Idle counter:
  - Counts only in RUN; clears on every `have_inst`.
  - Comparison is ≥TIMEOUT, saturating.
  - On timeout: `fail_code`=5, `fail_index`=current index.
- IDLE never times out, so a CPU held in reset does not cause failure.

## Timing
- Reset values: all outputs 0; state IDLE; idle counter 0.
- Reset mid-operation clears everything in the next cycle regardless of state.
- Latency: a compare at cycle N shows its result at cycle N+1 (`chk_fail`/`chk_pass`/`fail_*` registered, `gold_addr` advanced).
  - `gold_entry` must be valid combinationally within the same cycle `gold_addr` is presented.
  - A back-to-back `have_inst` every cycle is supported at full rate.
- `chk_done` = `chk_pass` | `chk_fail`, registered at the same edge.
- No handshake is issued toward the DUT; the checker is a pure observer.

## Test plan
- Matching stream: TRACE_DEPTH=4, four retirements matching the golden entries (pc 0x0,0x4,0x8,0xC with writes to x1..x4). The cycle after the 4th: `chk_pass`=1, `chk_done`=1, `retired_cnt`=4, `gold_addr`=4.
- Value mismatch: entry 2 golden value 0x10, DUT returns 0x11. Next cycle: `chk_fail`=1, `fail_code`=4, `fail_index`=2, `fail_got`=0x11, `fail_exp`=0x10. Later retirements are ignored.
- Priority: pc and value both wrong at entry 0 → `fail_code`=1 with pc values captured.
- x0 write: DUT ena=1, reg=0 against golden ena=0 → match. DUT ena=1, reg=5 against golden ena=0 → `fail_code`=2.
- Timeout: TIMEOUT=8, one retirement, then `have_inst` low for 8 cycles → `fail_code`=5, `fail_index`=1. Low `have_inst` for 100 cycles while in IDLE → no failure.
- Reset mid-run: assert `fpga_rst` for 1 cycle after 2 matches. Next cycle: all outputs 0, state IDLE; a fresh run from index 0 passes.

Source files
------------

// File: rtl/wb_trace_checker.sv
// ---------------------------------------------------------------------------
// wb_trace_checker
//
// Observes the per-instruction write-back trace of the miniRV SoC and checks
// every retired instruction against a golden trace held in an external
// asynchronous-read ROM. The checker never stalls the core; it only watches.
// Results are sticky until reset.
//
// Parameters
//   TRACE_DEPTH : number of golden entries; matching all of them is a pass
//   ADDR_W      : width of gold_addr / fail_index (2**ADDR_W >= TRACE_DEPTH)
//   TIMEOUT     : idle cycles tolerated between retirements once running
//
// Ports
//   fpga_clk            in   single clock
//   fpga_rst            in   synchronous active-high reset
//   debug_wb_have_inst  in   an instruction retires this cycle
//   debug_wb_pc         in   PC of the retiring instruction
//   debug_wb_ena        in   register-file write enable
//   debug_wb_reg        in   destination register
//   debug_wb_value      in   write data
//   gold_addr           out  registered index of the next expected entry
//   gold_entry          in   ROM data at gold_addr: {pc, ena, reg, value}
//   chk_done            out  sticky: check finished (pass or fail)
//   chk_pass            out  sticky: all TRACE_DEPTH entries matched
//   chk_fail            out  sticky: mismatch or timeout seen
//   fail_code           out  0 none, 1 pc, 2 ena, 3 reg, 4 value, 5 timeout
//   fail_index          out  entry index at the failure
//   fail_got            out  observed field that mismatched
//   fail_exp            out  golden field matching fail_got
//   retired_cnt         out  number of instructions that compared equal
//   dbg_state           out  FSM state: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL
//
// Trace interface semantics: there is no handshake. debug_wb_have_inst is a
// one-cycle qualifier; the trace fields are meaningful only while it is high,
// and every such cycle is exactly one retirement. gold_entry must be valid
// combinationally in the same cycle gold_addr is presented, which allows a
// retirement on every clock.
// ---------------------------------------------------------------------------
module wb_trace_checker #(
   parameter int TRACE_DEPTH = 1024,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT     = 65535
) (
   input  logic              fpga_clk,
   input  logic              fpga_rst,
   input  logic              debug_wb_have_inst,
   input  logic [31:0]       debug_wb_pc,
   input  logic              debug_wb_ena,
   input  logic [4:0]        debug_wb_reg,
   input  logic [31:0]       debug_wb_value,
   output logic [ADDR_W-1:0] gold_addr,
   input  logic [69:0]       gold_entry,
   output logic              chk_done,
   output logic              chk_pass,
   output logic              chk_fail,
   output logic [2:0]        fail_code,
   output logic [ADDR_W-1:0] fail_index,
   output logic [31:0]       fail_got,
   output logic [31:0]       fail_exp,
   output logic [31:0]       retired_cnt,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_PC      = 3'd1;
   localparam logic [2:0] FC_ENA     = 3'd2;
   localparam logic [2:0] FC_REG     = 3'd3;
   localparam logic [2:0] FC_VALUE   = 3'd4;
   localparam logic [2:0] FC_TIMEOUT = 3'd5;

   // The index needs one extra bit so it can hold TRACE_DEPTH itself when
   // TRACE_DEPTH == 2**ADDR_W. LAST_IDX is the index of the final entry.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(TRACE_DEPTH - 1);
   localparam logic [31:0]     TMO      = 32'(TIMEOUT);

   // Registered state
   state_t            state_q, state_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [31:0]       idle_q, idle_d;
   logic [31:0]       retired_q, retired_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic [2:0]        code_q, code_d;
   logic [ADDR_W-1:0] findex_q, findex_d;
   logic [31:0]       got_q, got_d;
   logic [31:0]       exp_q, exp_d;

   // Golden fields
   logic [31:0] g_pc;
   logic        g_ena;
   logic [4:0]  g_reg;
   logic [31:0] g_val;

   assign g_pc  = gold_entry[69:38];
   assign g_ena = gold_entry[37];
   assign g_reg = gold_entry[36:32];
   assign g_val = gold_entry[31:0];

   // A write to x0 is architecturally a no-op, so only "effective" writes are
   // compared; that way a core that asserts ena for x0 still matches a golden
   // trace that records no write.
   logic dut_w;
   logic gold_w;

   assign dut_w  = debug_wb_ena & (debug_wb_reg != 5'd0);
   assign gold_w = g_ena & (g_reg != 5'd0);

   // Field comparison with fixed priority pc > ena > reg > value. For an ena
   // mismatch the effective-write bits are reported, since those are what
   // disagreed.
   logic [2:0]  cmp_code;
   logic [31:0] cmp_got;
   logic [31:0] cmp_exp;

   always_comb begin
      cmp_code = FC_NONE;
      cmp_got  = 32'd0;
      cmp_exp  = 32'd0;
      if (debug_wb_pc != g_pc) begin
         cmp_code = FC_PC;
         cmp_got  = debug_wb_pc;
         cmp_exp  = g_pc;
      end else if (dut_w != gold_w) begin
         cmp_code = FC_ENA;
         cmp_got  = {31'd0, dut_w};
         cmp_exp  = {31'd0, gold_w};
      end else if (dut_w && (debug_wb_reg != g_reg)) begin
         cmp_code = FC_REG;
         cmp_got  = {27'd0, debug_wb_reg};
         cmp_exp  = {27'd0, g_reg};
      end else if (dut_w && (debug_wb_value != g_val)) begin
         cmp_code = FC_VALUE;
         cmp_got  = debug_wb_value;
         cmp_exp  = g_val;
      end
   end

   // Saturating increment of the idle counter; the timeout fires on the edge
   // where the count of consecutive idle RUN cycles reaches TIMEOUT.
   logic [31:0] idle_inc;
   assign idle_inc = (&idle_q) ? idle_q : idle_q + 32'd1;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      idle_d    = idle_q;
      retired_d = retired_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      code_d    = code_q;
      findex_d  = findex_q;
      got_d     = got_q;
      exp_d     = exp_q;

      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (debug_wb_have_inst) begin
               idle_d = 32'd0;
               if (cmp_code == FC_NONE) begin
                  idx_d     = idx_q + 1'b1;
                  retired_d = retired_q + 32'd1;
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_PASS;
                     pass_d  = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  state_d  = ST_FAIL;
                  fail_d   = 1'b1;
                  code_d   = cmp_code;
                  findex_d = idx_q[ADDR_W-1:0];
                  got_d    = cmp_got;
                  exp_d    = cmp_exp;
               end
            end else if (state_q == ST_RUN) begin
               // IDLE never counts, so a core held in reset is not a failure.
               idle_d = idle_inc;
               if (idle_inc >= TMO) begin
                  state_d  = ST_FAIL;
                  fail_d   = 1'b1;
                  code_d   = FC_TIMEOUT;
                  findex_d = idx_q[ADDR_W-1:0];
                  got_d    = 32'd0;
                  exp_d    = 32'd0;
               end
            end
         end
         default: begin
            // PASS and FAIL hold everything until reset.
         end
      endcase
   end

   always_ff @(posedge fpga_clk) begin
      if (fpga_rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         idle_q    <= 32'd0;
         retired_q <= 32'd0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         code_q    <= FC_NONE;
         findex_q  <= '0;
         got_q     <= 32'd0;
         exp_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         idle_q    <= idle_d;
         retired_q <= retired_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         code_q    <= code_d;
         findex_q  <= findex_d;
         got_q     <= got_d;
         exp_q     <= exp_d;
      end
   end

   // When TRACE_DEPTH == 2**ADDR_W the final index wraps to 0 on gold_addr;
   // by then the checker is in PASS and no longer reads the ROM.
   assign gold_addr   = idx_q[ADDR_W-1:0];
   assign chk_pass    = pass_q;
   assign chk_fail    = fail_q;
   assign chk_done    = pass_q | fail_q;
   assign fail_code   = code_q;
   assign fail_index  = findex_q;
   assign fail_got    = got_q;
   assign fail_exp    = exp_q;
   assign retired_cnt = retired_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_checker
//
// Self-checking bench for wb_trace_checker (TRACE_DEPTH=4, ADDR_W=3,
// TIMEOUT=8). A behavioural model tracks progress through the golden trace
// as plain counters and flags; a compare process checks every DUT output
// against it on each falling edge. Directed scenarios add literal checks,
// followed by randomized runs with mutated fields, gaps and resets.
// ---------------------------------------------------------------------------
module tb_wb_trace_checker;

   localparam int DEPTH = 4;
   localparam int AW    = 3;
   localparam int TMO   = 8;

   // ---------------- clock / reset ----------------
   logic fpga_clk = 1'b0;
   logic fpga_rst = 1'b1;
   always #5 fpga_clk = ~fpga_clk;

   // ---------------- DUT ----------------
   logic          have_inst = 1'b0;
   logic [31:0]   wb_pc     = '0;
   logic          wb_ena    = 1'b0;
   logic [4:0]    wb_reg    = '0;
   logic [31:0]   wb_value  = '0;
   logic [AW-1:0] gold_addr;
   logic [69:0]   gold_entry;
   logic          chk_done, chk_pass, chk_fail;
   logic [2:0]    fail_code;
   logic [AW-1:0] fail_index;
   logic [31:0]   fail_got, fail_exp, retired_cnt;
   logic [1:0]    dbg_state;

   logic [69:0] gold_rom [8];
   assign gold_entry = gold_rom[gold_addr];

   wb_trace_checker #(.TRACE_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
      .fpga_clk           (fpga_clk),
      .fpga_rst           (fpga_rst),
      .debug_wb_have_inst (have_inst),
      .debug_wb_pc        (wb_pc),
      .debug_wb_ena       (wb_ena),
      .debug_wb_reg       (wb_reg),
      .debug_wb_value     (wb_value),
      .gold_addr          (gold_addr),
      .gold_entry         (gold_entry),
      .chk_done           (chk_done),
      .chk_pass           (chk_pass),
      .chk_fail           (chk_fail),
      .fail_code          (fail_code),
      .fail_index         (fail_index),
      .fail_got           (fail_got),
      .fail_exp           (fail_exp),
      .retired_cnt        (retired_cnt),
      .dbg_state          (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Progress through the trace: how many entries matched, whether the run
   // has started, and the recorded verdict.
   int          m_idx = 0;
   int          m_idle = 0;
   bit          m_started = 0;
   bit          m_pass = 0;
   bit          m_fail = 0;
   int          m_code = 0;
   int          m_index = 0;
   logic [31:0] m_got = '0;
   logic [31:0] m_exp = '0;
   int          m_ret = 0;

   // Judge one retirement against one golden entry, reporting the
   // highest-priority disagreement.
   function automatic void judge(input logic [31:0] pc, input logic ena,
                                 input logic [4:0] rg, input logic [31:0] v,
                                 input logic [69:0] g, output int code,
                                 output logic [31:0] got, output logic [31:0] exp);
      logic [31:0] gpc, gv;
      logic [4:0]  grg;
      bit          dw, gw;
      gpc = g[69:38];
      grg = g[36:32];
      gv  = g[31:0];
      dw  = ena && (rg != 0);
      gw  = g[37] && (grg != 0);
      code = 0; got = 0; exp = 0;
      if (pc != gpc) begin
         code = 1; got = pc; exp = gpc;
      end else if (dw != gw) begin
         code = 2; got = 32'(dw); exp = 32'(gw);
      end else if (dw && rg != grg) begin
         code = 3; got = 32'(rg); exp = 32'(grg);
      end else if (dw && v != gv) begin
         code = 4; got = v; exp = gv;
      end
   endfunction

   always @(posedge fpga_clk) begin
      int          c;
      logic [31:0] g, e;
      if (fpga_rst) begin
         m_idx = 0; m_idle = 0; m_started = 0; m_pass = 0; m_fail = 0;
         m_code = 0; m_index = 0; m_got = 0; m_exp = 0; m_ret = 0;
      end else if (!m_pass && !m_fail) begin
         if (have_inst) begin
            judge(wb_pc, wb_ena, wb_reg, wb_value, gold_rom[m_idx], c, g, e);
            m_started = 1;
            m_idle = 0;
            if (c == 0) begin
               m_idx++;
               m_ret++;
               if (m_idx == DEPTH) m_pass = 1;
            end else begin
               m_fail = 1; m_code = c; m_index = m_idx; m_got = g; m_exp = e;
            end
         end else if (m_started) begin
            m_idle++;
            if (m_idle >= TMO) begin
               m_fail = 1; m_code = 5; m_index = m_idx; m_got = 0; m_exp = 0;
            end
         end
      end
   end

   // Compare process: every output against the model on each falling edge.
   always @(negedge fpga_clk) begin
      if (chk_en) begin
         cmp("chk_pass",    32'(chk_pass),    32'(m_pass));
         cmp("chk_fail",    32'(chk_fail),    32'(m_fail));
         cmp("chk_done",    32'(chk_done),    32'(m_pass || m_fail));
         cmp("gold_addr",   32'(gold_addr),   32'(m_idx % 8));
         cmp("retired_cnt", retired_cnt,      32'(m_ret));
         cmp("fail_code",   32'(fail_code),   32'(m_code));
         cmp("fail_index",  32'(fail_index),  32'(m_index));
         cmp("fail_got",    fail_got,         m_got);
         cmp("fail_exp",    fail_exp,         m_exp);
         cmp("dbg_state",   32'(dbg_state),
             m_pass ? 32'd2 : m_fail ? 32'd3 : m_started ? 32'd1 : 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [69:0] mk(input logic [31:0] pc, input logic ena,
                                      input logic [4:0] rg, input logic [31:0] v);
      return {pc, ena, rg, v};
   endfunction

   task automatic drive(input logic [31:0] pc, input logic ena,
                        input logic [4:0] rg, input logic [31:0] v);
      have_inst = 1'b1;
      wb_pc = pc; wb_ena = ena; wb_reg = rg; wb_value = v;
      @(negedge fpga_clk);
      have_inst = 1'b0;
   endtask

   task automatic retire_gold(input int i);
      logic [69:0] g;
      g = gold_rom[i];
      drive(g[69:38], g[37], g[36:32], g[31:0]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge fpga_clk);
   endtask

   task automatic do_reset();
      have_inst = 1'b0;
      fpga_rst = 1'b1;
      @(negedge fpga_clk);
      fpga_rst = 1'b0;
   endtask

   task automatic rom_default();
      for (int i = 0; i < 8; i++) gold_rom[i] = '0;
      for (int i = 0; i < DEPTH; i++)
         gold_rom[i] = mk(32'(4 * i), 1'b1, 5'(i + 1), 32'h100 + 32'(i));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [69:0] g;
      logic [31:0] pc, v;
      logic        en;
      logic [4:0]  rg;
      bit          gw;
      int          k;

      rom_default();
      fpga_rst = 1'b1;
      repeat (2) @(negedge fpga_clk);
      fpga_rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      cmp("rst_done",    32'(chk_done), 32'd0);
      cmp("rst_addr",    32'(gold_addr), 32'd0);
      cmp("rst_retired", retired_cnt, 32'd0);
      cmp("rst_state",   32'(dbg_state), 32'd0);

      // Matching stream, back-to-back
      for (int i = 0; i < DEPTH; i++) retire_gold(i);
      cmp("match_pass",    32'(chk_pass), 32'd1);
      cmp("match_done",    32'(chk_done), 32'd1);
      cmp("match_retired", retired_cnt, 32'd4);
      cmp("match_addr",    32'(gold_addr), 32'd4);
      drive(32'h10, 1'b1, 5'd9, 32'h9);
      cmp("match_frozen",  retired_cnt, 32'd4);

      // Value mismatch at entry 2
      do_reset();
      gold_rom[2] = mk(32'h8, 1'b1, 5'd3, 32'h10);
      retire_gold(0);
      retire_gold(1);
      drive(32'h8, 1'b1, 5'd3, 32'h11);
      cmp("val_fail",  32'(chk_fail), 32'd1);
      cmp("val_code",  32'(fail_code), 32'd4);
      cmp("val_index", 32'(fail_index), 32'd2);
      cmp("val_got",   fail_got, 32'h11);
      cmp("val_exp",   fail_exp, 32'h10);
      retire_gold(3);
      cmp("val_retired_frozen", retired_cnt, 32'd2);
      cmp("val_addr_frozen",    32'(gold_addr), 32'd2);

      // Priority: pc and value both wrong
      do_reset();
      rom_default();
      drive(32'h40, 1'b1, 5'd1, 32'hdead);
      cmp("prio_code", 32'(fail_code), 32'd1);
      cmp("prio_got",  fail_got, 32'h40);
      cmp("prio_exp",  fail_exp, 32'h0);

      // x0 write handling
      do_reset();
      gold_rom[0] = mk(32'h0, 1'b0, 5'd0, 32'h0);
      gold_rom[1] = mk(32'h4, 1'b0, 5'd0, 32'h0);
      drive(32'h0, 1'b1, 5'd0, 32'h55);
      cmp("x0_match",   retired_cnt, 32'd1);
      cmp("x0_nofail",  32'(chk_fail), 32'd0);
      drive(32'h4, 1'b1, 5'd5, 32'h77);
      cmp("x0_code",    32'(fail_code), 32'd2);
      cmp("x0_index",   32'(fail_index), 32'd1);

      // Timeout: IDLE never times out, RUN does after 8 idle cycles
      do_reset();
      rom_default();
      idle(100);
      cmp("idle_nofail", 32'(chk_fail), 32'd0);
      cmp("idle_state",  32'(dbg_state), 32'd0);
      retire_gold(0);
      idle(TMO - 1);
      cmp("tmo_early",  32'(chk_fail), 32'd0);
      idle(1);
      cmp("tmo_fail",   32'(chk_fail), 32'd1);
      cmp("tmo_code",   32'(fail_code), 32'd5);
      cmp("tmo_index",  32'(fail_index), 32'd1);

      // Reset mid-run, then a fresh passing run
      do_reset();
      retire_gold(0);
      retire_gold(1);
      do_reset();
      cmp("mid_retired", retired_cnt, 32'd0);
      cmp("mid_addr",    32'(gold_addr), 32'd0);
      cmp("mid_done",    32'(chk_done), 32'd0);
      cmp("mid_state",   32'(dbg_state), 32'd0);
      for (int i = 0; i < DEPTH; i++) retire_gold(i);
      cmp("mid_pass",    32'(chk_pass), 32'd1);

      // Randomized runs: random golden traces, occasional mutated fields,
      // gaps long enough to time out, and resets mid-run.
      for (int run = 0; run < 60; run++) begin
         do_reset();
         for (int i = 0; i < 8; i++) gold_rom[i] = '0;
         for (int i = 0; i < DEPTH; i++)
            gold_rom[i] = mk($urandom, 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                             $urandom);
         k = 0;
         for (int step = 0; step < 7; step++) begin
            if ($urandom_range(0, 9) == 0) idle(TMO + 1);
            else idle($urandom_range(0, 2));
            if ($urandom_range(0, 24) == 0) begin
               do_reset();
               k = 0;
            end
            g  = gold_rom[(k < DEPTH) ? k : DEPTH - 1];
            pc = g[69:38]; en = g[37]; rg = g[36:32]; v = g[31:0];
            gw = en && (rg != 0);
            if (!gw) begin
               en = 1'($urandom_range(0, 1));
               rg = en ? 5'd0 : 5'($urandom_range(0, 31));
               v  = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 3))
                  0: pc = pc ^ (32'd1 << $urandom_range(0, 31));
                  1: if (gw) en = 1'b0;
                     else begin en = 1'b1; rg = 5'($urandom_range(1, 31)); end
                  2: rg = rg ^ (5'd1 << $urandom_range(0, 4));
                  default: v = v ^ (32'd1 << $urandom_range(0, 31));
               endcase
            end
            drive(pc, en, rg, v);
            k++;
         end
         idle(2);
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
